hdmi_audio_clock_regen: RTL and testbench



---
 rtl/hdmi_audio_pkg.sv | 16 +
 rtl/frac_strobe_gen.sv | 50 +++++
 rtl/hdmi_audio_clock_regen.sv | 99 +++++++++
 tb/tb_hdmi_audio_clock_regen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared constants and types for the HDMI audio clock-regeneration path.
// The ACR pair type is what the packet generator consumes.
package hdmi_audio_pkg;

   localparam int unsigned SAMPLE_RATE_48K = 48000;
   localparam int unsigned ACR_N_48K       = 6144;
   localparam int          FREQ_W          = 27;
   localparam int          CTS_W           = 20;
   localparam int          ACR_N_W         = 20;

   typedef struct packed {
      logic [ACR_N_W-1:0] n;
      logic [CTS_W-1:0]   cts;
   } acr_pair_t;

endpackage

// File: rtl/frac_strobe_gen.sv
// Fractional-rate strobe: adds SAMPLE_RATE per cycle and fires on wrap past clk_hz.
// Any change of clk_hz restarts the phase so windows stay exact for the new clock.
module frac_strobe_gen #(
   parameter int unsigned SAMPLE_RATE = hdmi_audio_pkg::SAMPLE_RATE_48K,
   parameter int          FREQ_W      = hdmi_audio_pkg::FREQ_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [FREQ_W-1:0] clk_hz,
   output logic              en,
   output logic              restart,
   output logic              fire
);
   import hdmi_audio_pkg::*;

   localparam logic [FREQ_W:0] SR_ADD = (FREQ_W+1)'(SAMPLE_RATE);
   localparam logic [FREQ_W:0] EN_MIN = (FREQ_W+1)'(2 * SAMPLE_RATE);

   logic [FREQ_W-1:0] acc_q, acc_d;
   logic [FREQ_W-1:0] clk_hz_q, clk_hz_d;
   logic [FREQ_W:0]   sum;

   always_comb begin
      sum      = {1'b0, acc_q} + SR_ADD;
      restart  = (clk_hz != clk_hz_q);
      en       = ({1'b0, clk_hz} >= EN_MIN);
      clk_hz_d = clk_hz;
      fire     = 1'b0;
      acc_d    = acc_q;
      if (restart || !en) begin
         acc_d = '0;
      end else if (sum >= {1'b0, clk_hz_q}) begin
         acc_d = FREQ_W'(sum - {1'b0, clk_hz_q});
         fire  = 1'b1;
      end else begin
         acc_d = sum[FREQ_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q    <= '0;
         clk_hz_q <= clk_hz;
      end else begin
         acc_q    <= acc_d;
         clk_hz_q <= clk_hz_d;
      end
   end

endmodule

// File: rtl/hdmi_audio_clock_regen.sv
// 48 kHz audio strobe in the pixel-clock domain plus measured N/CTS for ACR packets.
// CTS = pixel clocks spanned by ACR_N/128 audio samples.
module hdmi_audio_clock_regen #(
   parameter int unsigned SAMPLE_RATE = hdmi_audio_pkg::SAMPLE_RATE_48K,
   parameter int unsigned ACR_N       = hdmi_audio_pkg::ACR_N_48K,
   parameter int          FREQ_W      = hdmi_audio_pkg::FREQ_W,
   parameter int          CTS_W       = hdmi_audio_pkg::CTS_W
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [FREQ_W-1:0]                  clk_hz,
   output logic                               audio_sample,
   output logic [hdmi_audio_pkg::ACR_N_W-1:0] acr_n,
   output logic [CTS_W-1:0]                   acr_cts,
   output logic                               acr_cts_stb,
   output logic                               acr_valid
);
   import hdmi_audio_pkg::*;

   localparam int unsigned     WIN_SMP  = ACR_N / 128;
   localparam int              SMP_W    = (WIN_SMP > 1) ? $clog2(WIN_SMP) : 1;
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_SMP - 1);

   logic en, restart, fire;

   frac_strobe_gen #(
      .SAMPLE_RATE (SAMPLE_RATE),
      .FREQ_W      (FREQ_W)
   ) u_strobe (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_hz  (clk_hz),
      .en      (en),
      .restart (restart),
      .fire    (fire)
   );

   logic [CTS_W-1:0] cyc_cnt_q, cyc_cnt_d, cyc_inc;
   logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [CTS_W-1:0] acr_cts_q, acr_cts_d;
   logic             acr_cts_stb_q, acr_cts_stb_d;
   logic             acr_valid_q, acr_valid_d;
   logic             audio_sample_q, audio_sample_d;

   always_comb begin
      cyc_inc        = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
      cyc_cnt_d      = cyc_cnt_q;
      smp_cnt_d      = smp_cnt_q;
      acr_cts_d      = acr_cts_q;
      acr_valid_d    = acr_valid_q;
      acr_cts_stb_d  = 1'b0;
      audio_sample_d = 1'b0;
      // acr_cts survives a restart; only validity is withdrawn
      if (restart || !en) begin
         cyc_cnt_d   = '0;
         smp_cnt_d   = '0;
         acr_valid_d = 1'b0;
      end else begin
         audio_sample_d = fire;
         cyc_cnt_d      = cyc_inc;
         if (fire) begin
            if (smp_cnt_q == SMP_LAST) begin
               acr_cts_d     = cyc_inc;
               acr_cts_stb_d = 1'b1;
               acr_valid_d   = 1'b1;
               cyc_cnt_d     = '0;
               smp_cnt_d     = '0;
            end else begin
               smp_cnt_d = smp_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cyc_cnt_q      <= '0;
         smp_cnt_q      <= '0;
         acr_cts_q      <= '0;
         acr_cts_stb_q  <= 1'b0;
         acr_valid_q    <= 1'b0;
         audio_sample_q <= 1'b0;
      end else begin
         cyc_cnt_q      <= cyc_cnt_d;
         smp_cnt_q      <= smp_cnt_d;
         acr_cts_q      <= acr_cts_d;
         acr_cts_stb_q  <= acr_cts_stb_d;
         acr_valid_q    <= acr_valid_d;
         audio_sample_q <= audio_sample_d;
      end
   end

   assign audio_sample = audio_sample_q;
   assign acr_n        = ACR_N_W'(ACR_N);
   assign acr_cts      = acr_cts_q;
   assign acr_cts_stb  = acr_cts_stb_q;
   assign acr_valid    = acr_valid_q;

endmodule

// File: tb/tb_hdmi_audio_clock_regen.sv
// Bench for hdmi_audio_clock_regen: closed-form sample-count model checked every cycle,
// plus directed window/interval/switch/reset scenarios and randomized frequency segments.
module tb_hdmi_audio_clock_regen;

   localparam longint unsigned SR    = 48000;
   localparam longint unsigned SPW   = 48;
   localparam longint unsigned CMAX  = (64'd1 << 20) - 1;

   logic        clk;
   logic        reset_n;
   logic [26:0] clk_hz;
   logic        audio_sample;
   logic [19:0] acr_n;
   logic [19:0] acr_cts;
   logic        acr_cts_stb;
   logic        acr_valid;

   hdmi_audio_clock_regen dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .clk_hz       (clk_hz),
      .audio_sample (audio_sample),
      .acr_n        (acr_n),
      .acr_cts      (acr_cts),
      .acr_cts_stb  (acr_cts_stb),
      .acr_valid    (acr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Model: t = enabled cycles since restart; samples emitted so far = floor(t*SR/f).
   longint unsigned m_fq, m_t, m_tl, m_cts;
   bit              m_as, m_stb, m_valid;

   function automatic longint unsigned nsmp(input longint unsigned t, input longint unsigned f);
      return (t * SR) / f;
   endfunction

   task automatic model_step();
      m_as  = 0;
      m_stb = 0;
      if (!reset_n) begin
         m_fq = clk_hz; m_t = 0; m_tl = 0; m_valid = 0; m_cts = 0;
      end else if (64'(clk_hz) != m_fq) begin
         m_fq = clk_hz; m_t = 0; m_tl = 0; m_valid = 0;
      end else if (64'(clk_hz) < 2 * SR) begin
         m_t = 0; m_tl = 0; m_valid = 0;
      end else begin
         m_t++;
         m_as = nsmp(m_t, m_fq) > nsmp(m_t - 1, m_fq);
         if (m_as && (nsmp(m_t, m_fq) % SPW == 0)) begin
            m_cts   = (m_t - m_tl > CMAX) ? CMAX : m_t - m_tl;
            m_tl    = m_t;
            m_stb   = 1;
            m_valid = 1;
         end
      end
   endtask

   function automatic bit pred_fire();
      return (m_fq >= 2 * SR) && (64'(clk_hz) == m_fq) &&
             (nsmp(m_t + 1, m_fq) > nsmp(m_t, m_fq));
   endfunction

   task automatic cyc();
      logic [19:0] ec;
      @(posedge clk);
      model_step();
      @(negedge clk);
      ec = m_cts[19:0];
      chk("outs", {21'd0, acr_n, audio_sample, acr_cts_stb, acr_valid, acr_cts},
                  {21'd0, 20'd6144, m_as, m_stb, m_valid, ec});
   endtask

   // n cycles; counts strobes/stbs, checks inter-strobe spacing (lo>0) and window CTS (exp_cts>0)
   task automatic run_seg(input int n, input int lo, input int hi, input int exp_cts,
                          output int nstr, output int nstb, output int nbad, output int first_stb);
      int last;
      nstr = 0; nstb = 0; nbad = 0; first_stb = 0; last = -1;
      for (int i = 1; i <= n; i++) begin
         cyc();
         if (audio_sample) begin
            if (lo > 0 && last >= 0 && !((i - last) >= lo && (i - last) <= hi)) nbad++;
            last = i;
            nstr++;
         end
         if (acr_cts_stb) begin
            nstb++;
            if (first_stb == 0) first_stb = i;
            if (exp_cts > 0) chk("cts_win", 64'(acr_cts), 64'(exp_cts));
         end
      end
   endtask

   task automatic wait_fire(input string tag);
      bit found = 0;
      for (int i = 0; i < 5000; i++) begin
         if (pred_fire()) begin found = 1; break; end
         cyc();
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   initial begin
      int nstr, nstb, nbad, fst, k;
      bit seen;
      reset_n = 1'b0;
      clk_hz  = 27'd28000000;
      @(negedge clk);
      cyc(); cyc();
      chk("rst_state", {audio_sample, acr_cts_stb, acr_valid, acr_cts}, 64'd0);

      // 28 MHz from reset: one exact window
      reset_n = 1'b1;
      run_seg(28000, 583, 584, 28000, nstr, nstb, nbad, fst);
      chk("n_strobe_28m", 64'(nstr), 64'd48);
      chk("stb_at_28m", 64'(fst), 64'd28000);
      chk("intv_28m", 64'(nbad), 64'd0);
      run_seg(5, 0, 0, 0, nstr, nstb, nbad, fst);
      chk("valid_28m", 64'(acr_valid), 64'd1);
      chk("acr_n", 64'(acr_n), 64'd6144);

      // 74.25 MHz strobe spacing
      clk_hz = 27'd74250000;
      run_seg(3200, 1546, 1547, 0, nstr, nstb, nbad, fst);
      chk("n_strobe_74m", 64'(nstr), 64'd2);
      chk("intv_74m", 64'(nbad), 64'd0);

      // two windows, then switch exactly on a firing cycle mid-window
      clk_hz = 27'd252000;
      run_seg(505, 0, 0, 252, nstr, nstb, nbad, fst);
      chk("nstb_252k", 64'(nstb), 64'd2);
      run_seg(100, 0, 0, 0, nstr, nstb, nbad, fst);
      wait_fire("find_fire_sw");
      clk_hz = 27'd800000;
      cyc();
      chk("sw_no_strobe", 64'(audio_sample), 64'd0);
      chk("sw_valid_drop", 64'(acr_valid), 64'd0);
      run_seg(800, 0, 0, 800, nstr, nstb, nbad, fst);
      chk("nstb_800k", 64'(nstb), 64'd1);
      chk("valid_800k", 64'(acr_valid), 64'd1);

      // below enable threshold, then recover
      clk_hz = 27'd90000;
      run_seg(4000, 0, 0, 0, nstr, nstb, nbad, fst);
      chk("dis_strobes", 64'(nstr + nstb), 64'd0);
      chk("dis_valid", 64'(acr_valid), 64'd0);
      clk_hz = 27'd24000000;
      run_seg(24001, 0, 0, 24000, nstr, nstb, nbad, fst);
      chk("nstb_24m", 64'(nstb), 64'd1);

      // reset pulse on a firing cycle
      clk_hz = 27'd500000;
      run_seg(600, 0, 0, 500, nstr, nstb, nbad, fst);
      wait_fire("find_fire_rst");
      reset_n = 1'b0;
      cyc();
      chk("rst_fire", {audio_sample, acr_cts_stb, acr_valid, acr_cts}, 64'd0);
      reset_n = 1'b1;
      k = 0; seen = 0;
      for (int i = 1; i <= 100; i++) begin
         cyc();
         if (audio_sample) begin k = i; seen = 1; break; end
      end
      chk("rel_latency", 64'(k), 64'd11);

      // stability: 100 windows at the lowest legal rate (exactly 2 cycles per sample)
      clk_hz = 27'd96000;
      run_seg(9601, 2, 2, 96, nstr, nstb, nbad, fst);
      chk("stab_strobes", 64'(nstr), 64'd4800);
      chk("stab_windows", 64'(nstb), 64'd100);
      chk("stab_intv", 64'(nbad), 64'd0);

      // randomized frequencies, occasional resets and disabled spans
      for (int s = 0; s < 16; s++) begin
         int unsigned f;
         f = $urandom_range(400000, 96000);
         if ($urandom_range(1, 0) == 1) f = (f / 1000) * 1000;
         if ($urandom_range(7, 0) == 0) f = $urandom_range(95999, 0);
         clk_hz = 27'(f);
         if ($urandom_range(4, 0) == 0) begin
            reset_n = 1'b0; cyc(); reset_n = 1'b1;
         end
         run_seg(int'($urandom_range(900, 100)), 0, 0, 0, nstr, nstb, nbad, fst);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
